// File: rtl/mealy_seq_11.sv
// Mealy serial pattern detector: y flags the cycle in which x completes PATTERN.
// The state register holds how many pattern bits are currently matched.
module mealy_seq_11 #(
    parameter int                     PATTERN_LEN = 2,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 2'b11,
    parameter bit                     OVERLAP     = 1'b1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic x,
    output logic y,
    output logic [((PATTERN_LEN <= 1) ? 1 : $clog2(PATTERN_LEN))-1:0] o_dbg_state
);

    localparam int SW = (PATTERN_LEN <= 1) ? 1 : $clog2(PATTERN_LEN);

    localparam logic [SW-1:0] S_IDLE = '0;
    localparam logic [SW-1:0] S_LAST = SW'(PATTERN_LEN - 1);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic          w_match;

    // Longest prefix of PATTERN (shorter than the whole pattern) that is a
    // suffix of the matched prefix followed by b. Pattern bit j counts from the MSB.
    function automatic logic [SW-1:0] f_next(input logic [SW-1:0] s, input logic b);
        logic [SW-1:0] best;
        logic          ok;
        logic          tbit;
        int            idx;
        best = S_IDLE;
        tbit = 1'b0;
        idx  = 0;
        for (int k = 1; k < PATTERN_LEN; k++) begin
            ok = (k <= int'(s) + 1);
            for (int j = 0; j < PATTERN_LEN - 1; j++) begin
                if (ok && (j < k)) begin
                    idx  = int'(s) + 1 - k + j;
                    tbit = (idx < int'(s)) ? PATTERN[PATTERN_LEN-1-idx] : b;
                    if (tbit != PATTERN[PATTERN_LEN-1-j]) ok = 1'b0;
                end
            end
            if (ok) best = SW'(k);
        end
        return best;
    endfunction

    assign w_match = (r_state == S_LAST) && (x == PATTERN[0]);

    always_comb begin
        w_next = f_next(r_state, x);
        if (w_match && !OVERLAP) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Reset gates the output directly so it drops between clock edges.
    assign y           = !rst_b && w_match;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mealy_seq_11.sv
// Bench for mealy_seq_11: three configurations driven by one stream, checked
// against a bit-history reference model through an expected-value queue.
module tb_mealy_seq_11;

    localparam int NC = 3;

    logic clk;
    logic rst_b;
    logic x;
    logic y_a, y_b, y_c;
    logic [0:0] st_a, st_b;
    logic [1:0] st_c;

    int cfg_len [NC] = '{2, 2, 3};
    int cfg_pat [NC] = '{3, 3, 5};
    bit cfg_ovl [NC] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] hist [NC];
    int          hcnt [NC];

    logic [2:0] exp_q[$];
    event       ev_sample;
    int         n_checks;
    int         n_err;

    mealy_seq_11 #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut_a (
        .clk(clk), .rst_b(rst_b), .x(x), .y(y_a), .o_dbg_state(st_a));
    mealy_seq_11 #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0)) dut_b (
        .clk(clk), .rst_b(rst_b), .x(x), .y(y_b), .o_dbg_state(st_b));
    mealy_seq_11 #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) dut_c (
        .clk(clk), .rst_b(rst_b), .x(x), .y(y_c), .o_dbg_state(st_c));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the last cfg_len bits received (including the current x)
    // equal the pattern, counting only bits since reset or a non-overlap match.
    function automatic bit model_match(int c, logic xv);
        logic [31:0] s;
        logic [31:0] mask;
        s    = {hist[c][30:0], xv};
        mask = (32'd1 << cfg_len[c]) - 32'd1;
        return (hcnt[c] + 1 >= cfg_len[c]) && ((s & mask) == 32'(cfg_pat[c]));
    endfunction

    always @(posedge clk) begin
        if (!rst_b) begin
            for (int c = 0; c < NC; c++) begin
                hist[c] <= {hist[c][30:0], x};
                if (!cfg_ovl[c] && model_match(c, x)) hcnt[c] <= 0;
                else hcnt[c] <= (hcnt[c] < 31) ? hcnt[c] + 1 : hcnt[c];
            end
        end
    end

    // driver tasks
    task automatic apply(input logic r, input logic xv);
        logic [2:0] e;
        rst_b = r;
        x     = xv;
        if (r) begin
            for (int c = 0; c < NC; c++) begin
                hist[c] = '0;
                hcnt[c] = 0;
            end
        end
        #1;
        for (int c = 0; c < NC; c++) e[c] = r ? 1'b0 : model_match(c, xv);
        exp_q.push_back(e);
        ->ev_sample;
    endtask

    task automatic step(input logic r, input logic xv);
        @(negedge clk);
        apply(r, xv);
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
    endtask

    // scoreboard monitor
    initial begin
        logic [2:0] e;
        logic [2:0] a;
        forever begin
            @(ev_sample);
            a = {y_c, y_b, y_a};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_underflow: actual=%b required=<entry>", a);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL y_cba t=%0t: actual=%b required=%b", $time, a, e);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        for (int c = 0; c < NC; c++) begin
            hist[c] = '0;
            hcnt[c] = 0;
        end
        rst_b = 1'b1;
        x     = 1'b0;

        // reset held with x toggling, including mid-cycle
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            #2 apply(1'b1, 1'b0);
        end
        @(negedge clk);
        if (st_a !== 1'b0 || st_b !== 1'b0 || st_c !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: actual=%b/%b/%0d required=0/0/0", st_a, st_b, st_c);
        end
        n_checks++;

        // default sequence then isolated ones
        run_bits(16'b010111, 6);
        run_bits(16'b101010, 6);

        // Mealy behaviour: toggle x inside one cycle while matched
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #1 apply(1'b0, 1'b0);
        #1 apply(1'b0, 1'b1);

        // async reset between edges, then release with x=1
        #1 apply(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // non-overlap run of ones and the 101 pattern, each from reset
        step(1'b1, 1'b0);
        run_bits(16'b1111, 4);
        step(1'b1, 1'b0);
        run_bits(16'b10101, 5);
        run_bits(16'b1101101, 7);

        // random stream with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                #2 apply(rst_b, ~x);
            end
        end

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
